// File: rtl/fifo_gray_ptr_if.sv
// Write/read port bundle for fifo_gray_ptr.
// With FIFO_LEVEL_EN defined the bundle also carries fill_level.
interface fifo_gray_ptr_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_full;
  logic                  rd_empty;
`ifdef FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0]   fill_level;
`endif

  // Producer/consumer side: drives requests and write data.
  modport master (
    output wr_en,
    output wr_data,
    output rd_en,
`ifdef FIFO_LEVEL_EN
    input  fill_level,
`endif
    input  rd_data,
    input  wr_full,
    input  rd_empty
  );

  // FIFO side: accepts requests and returns data and status.
  modport slave (
    input  wr_en,
    input  wr_data,
    input  rd_en,
`ifdef FIFO_LEVEL_EN
    output fill_level,
`endif
    output rd_data,
    output wr_full,
    output rd_empty
  );
endinterface

// File: rtl/fifo_gray_ptr.sv
// Single-clock FIFO with binary wrap-bit pointers mirrored in Gray code.
// Both flags are registered and computed from the next-state pointers.
// Optional feature: define FIFO_LEVEL_EN to add the registered fill_level output.
module fifo_gray_ptr #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic          clk,
  input  logic          rst,
  fifo_gray_ptr_if.slave bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_gray;
  logic [PTR_WIDTH-1:0]  rd_gray;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_full_q;
  logic                  rd_empty_q;

  logic                  wr_fire;
  logic                  rd_fire;
  logic [PTR_WIDTH-1:0]  wr_ptr_next;
  logic [PTR_WIDTH-1:0]  rd_ptr_next;
  logic [PTR_WIDTH-1:0]  wr_gray_next;
  logic [PTR_WIDTH-1:0]  rd_gray_next;
  logic                  wr_full_next;
  logic                  rd_empty_next;

  function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Accept decisions, next pointers and next flags (flags gated by pre-edge state).
  always_comb begin
    wr_fire       = bus.wr_en & ~wr_full_q;
    rd_fire       = bus.rd_en & ~rd_empty_q;
    wr_ptr_next   = wr_ptr + PTR_WIDTH'(wr_fire);
    rd_ptr_next   = rd_ptr + PTR_WIDTH'(rd_fire);
    wr_gray_next  = wr_gray;
    rd_gray_next  = rd_gray;
    if (wr_fire) begin
      wr_gray_next = bin2gray(wr_ptr_next);
    end
    if (rd_fire) begin
      rd_gray_next = bin2gray(rd_ptr_next);
    end
    rd_empty_next = (wr_gray_next == rd_gray_next);
    // A pointer DEPTH ahead differs from the other only in its top two Gray bits.
    wr_full_next  = (wr_gray_next ==
                     {~rd_gray_next[PTR_WIDTH-1 -: 2], rd_gray_next[PTR_WIDTH-3:0]});
  end

  // Pointers, Gray mirrors and flags; reset leaves the FIFO empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_gray    <= '0;
      rd_gray    <= '0;
      wr_full_q  <= 1'b0;
      rd_empty_q <= 1'b1;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      wr_gray    <= wr_gray_next;
      rd_gray    <= rd_gray_next;
      wr_full_q  <= wr_full_next;
      rd_empty_q <= rd_empty_next;
    end
  end

  // Storage array; not reset, stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  // Registered read data; holds its value when no read is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (rd_fire) begin
      rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.wr_full  = wr_full_q;
  assign bus.rd_empty = rd_empty_q;

`ifdef FIFO_LEVEL_EN
  logic [PTR_WIDTH-1:0] fill_level_q;

  // Occupancy after each edge, taken from the next-state pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_level_q <= '0;
    end else begin
      fill_level_q <= wr_ptr_next - rd_ptr_next;
    end
  end

  assign bus.fill_level = fill_level_q;
`endif

endmodule

// File: tb/tb_fifo_gray_ptr.sv
// Directed testbench for fifo_gray_ptr (DEPTH=16, DATA_WIDTH=8).
module tb_fifo_gray_ptr;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_rd;
  int            max_level;

  fifo_gray_ptr_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fifo_gray_ptr #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i * 37 + 5);
  endfunction

  // One clock: drive at negedge, expected outcome from a queue model, sample at next negedge.
  task automatic step(input string tag, input logic wr, input logic [DW-1:0] d, input logic rd);
    bit wr_ok;
    bit rd_ok;
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    @(posedge clk);
    wr_ok = wr && (q.size() < DEPTH);
    rd_ok = rd && (q.size() > 0);
    if (rd_ok) exp_rd = q.pop_front();
    if (wr_ok) q.push_back(d);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(exp_rd));
    check({tag, ".wr_full"}, 32'(bus.wr_full), 32'(q.size() == DEPTH));
    check({tag, ".rd_empty"}, 32'(bus.rd_empty), 32'(q.size() == 0));
`ifdef FIFO_LEVEL_EN
    check({tag, ".level"}, 32'(bus.fill_level), 32'(q.size()));
    if (int'(bus.fill_level) > max_level) max_level = int'(bus.fill_level);
`endif
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    max_level   = 0;
    exp_rd      = '0;
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;

    // Reset held for two cycles, released between edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset.rd_empty", 32'(bus.rd_empty), 32'd1);
    check("reset.wr_full", 32'(bus.wr_full), 32'd0);
    check("reset.rd_data", 32'(bus.rd_data), 32'd0);
`ifdef FIFO_LEVEL_EN
    check("reset.level", 32'(bus.fill_level), 32'd0);
`endif
    @(negedge clk);

    // Fill: 16 writes then a dropped 17th.
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1'b1, pat(i), 1'b0);
      if (i == 0) check("fill.first_not_empty", 32'(bus.rd_empty), 32'd0);
      if (i == DEPTH - 2) check("fill.15_not_full", 32'(bus.wr_full), 32'd0);
    end
    check("fill.full_after_16", 32'(bus.wr_full), 32'd1);
    step("fill17", 1'b1, 8'hEE, 1'b0);
    check("fill17.still_full", 32'(bus.wr_full), 32'd1);

    // Drain: 16 reads in order, then a dropped 17th read.
    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, 8'h00, 1'b1);
      if (i == 0) check("drain.first_word", 32'(bus.rd_data), 32'h05);
      if (i == DEPTH - 1) check("drain.last_word", 32'(bus.rd_data), 32'(pat(15)));
    end
    check("drain.empty_after_16", 32'(bus.rd_empty), 32'd1);
    step("drain17", 1'b0, 8'h00, 1'b1);
    check("drain17.hold", 32'(bus.rd_data), 32'(pat(15)));

    // Partial: 8 in / 8 out three times, wrapping the pointers.
    max_level = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) step("part_wr", 1'b1, pat(100 + r * 8 + i), 1'b0);
      for (int i = 0; i < 8; i++) step("part_rd", 1'b0, 8'h00, 1'b1);
      check("part.round_last", 32'(bus.rd_data), 32'(pat(100 + r * 8 + 7)));
    end
`ifdef FIFO_LEVEL_EN
    check("part.peak_level", 32'(max_level), 32'd8);
`endif

    // Concurrent: 4 stored, 10 cycles of simultaneous write and read.
    for (int i = 0; i < 4; i++) step("conc_pre", 1'b1, pat(200 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step("conc", 1'b1, pat(204 + i), 1'b1);
      check("conc.order", 32'(bus.rd_data), 32'(pat(200 + i)));
    end
    // Top up to full, then both enables while full.
    for (int i = 0; i < 12; i++) step("conc_fill", 1'b1, pat(214 + i), 1'b0);
    check("conc.full", 32'(bus.wr_full), 32'd1);
    step("full_both", 1'b1, 8'h77, 1'b1);
    check("full_both.read", 32'(bus.rd_data), 32'(pat(210)));
    check("full_both.unfull", 32'(bus.wr_full), 32'd0);
    // Drain and confirm the dropped word never appears.
    while (q.size() > 0) step("conc_drain", 1'b0, 8'h00, 1'b1);
    check("conc_drain.last", 32'(bus.rd_data), 32'(pat(225)));

    // Simultaneous on empty: write wins, read dropped.
    step("empty_both", 1'b1, 8'h3C, 1'b1);
    check("empty_both.not_empty", 32'(bus.rd_empty), 32'd0);
    step("empty_both_rd", 1'b0, 8'h00, 1'b1);
    check("empty_both.word", 32'(bus.rd_data), 32'h3C);

    // Mid-operation asynchronous reset while holding 5 words.
    for (int i = 0; i < 5; i++) step("mid_pre", 1'b1, pat(300 + i), 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst.rd_empty", 32'(bus.rd_empty), 32'd1);
    check("midrst.wr_full", 32'(bus.wr_full), 32'd0);
    check("midrst.rd_data", 32'(bus.rd_data), 32'd0);
`ifdef FIFO_LEVEL_EN
    check("midrst.level", 32'(bus.fill_level), 32'd0);
`endif
    q.delete();
    exp_rd = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.release_empty", 32'(bus.rd_empty), 32'd1);
    @(negedge clk);
    step("post_rd_empty", 1'b0, 8'h00, 1'b1);
    check("post.no_stale", 32'(bus.rd_data), 32'd0);
    step("post_wr", 1'b1, 8'hA5, 1'b0);
    step("post_rd", 1'b0, 8'h00, 1'b1);
    check("post.next_word", 32'(bus.rd_data), 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_gray_ptr.md
Name: fifo_gray_ptr

Overview:
- Single-clock first-in first-out data buffer with a write port and a read port.
- Used as the synchronous core and reference model of the project's asynchronous FIFO family.
- Addresses use binary pointers with an extra wrap bit. Each pointer is mirrored in Gray code so the block can later be split into two clock domains.
- Full and empty flags are registered and non-speculative.

Parameters:
- DATA_WIDTH, 8, width of the write-data and read-data words.
- DEPTH, 16, number of storage entries; must be a power of two, at least 4.
- ADDR_WIDTH, log2(DEPTH) (4), derived; not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset; 0 resets, 1 runs.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  data to write.
- rd_en  input  1  read request.
- rd_data  output  DATA_WIDTH  registered read data.
- wr_full  output  1  registered; 1 = no free entry.
- rd_empty  output  1  registered; 1 = no stored entry.

Behaviour:
- Reset: asserting rst low immediately clears wr_ptr and rd_ptr (ADDR_WIDTH+1 bits each), clears both Gray mirrors, rd_data=0, wr_full=0, rd_empty=1. Storage array is not reset.
- Reset mid-operation discards all contents. After release the FIFO is empty. Stale array data is never presented.
- Write: on a rising edge with wr_en=1 and wr_full=0, mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data and wr_ptr increments. With wr_full=1 the write is dropped silently and no state changes.
- Read: on a rising edge with rd_en=1 and rd_empty=0, rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]] and rd_ptr increments. Latency is 1 cycle: data is valid after the edge that accepts the read.
- With rd_empty=1 the read is dropped and rd_data holds its last value.
- Pointer wrap: the low ADDR_WIDTH bits wrap modulo DEPTH. The MSB toggles on each wrap.
- Gray mirror: gray = bin ^ (bin >> 1), registered alongside each pointer.
- Next-state flags, computed from next pointers:
  - rd_empty_next = (wr_gray_next == rd_gray_next).
  - wr_full_next = (wr_gray_next == {~rd_gray_next[top two bits], rd_gray_next[remaining bits]}).
  - Equivalent binary rule: addresses equal and MSBs differ.
- Flag timing:
  - rd_empty deasserts on the edge that writes the first word, so the word is readable next cycle.
  - wr_full asserts on the edge that writes the DEPTH-th word.
- Simultaneous write and read, neither flag set: both occur and the occupancy is unchanged.
- Simultaneous, FIFO full: the read occurs, the write is dropped (gated by pre-edge wr_full), and wr_full clears.
- Simultaneous, FIFO empty: the write occurs, the read is dropped, and rd_empty clears. The new word is returned on a later read.
- Ordering: words are read in exactly the order written. No word is lost or duplicated.

Optional Feature:
- Macro FIFO_LEVEL_EN.
- Defined: adds output port fill_level, width ADDR_WIDTH+1, registered. It equals wr_ptr - rd_ptr after each edge (0..DEPTH) and resets to 0 asynchronously with rst.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> rd_empty=1, wr_full=0, rd_data=0.
- Fill: 16 consecutive writes of random bytes, then a 17th write with wr_en=1 -> wr_full=1 after the 16th write; 17th write ignored; rd_empty=0 after the first write.
- Drain: 16 consecutive reads after fill -> rd_data matches write order with 1-cycle latency; rd_empty=1 after the 16th read; a 17th read leaves rd_data unchanged.
- Partial: write 8 bytes, read 8 bytes, repeat 3 times so the pointers wrap -> data order preserved across the wrap; fill_level peaks at 8 when FIFO_LEVEL_EN is defined.
- Concurrent: with 4 words stored, wr_en=rd_en=1 for 10 cycles -> occupancy stays 4, flags stay 0, output stream in order. When full with both enables set -> one word read, write dropped, wr_full=0.
- Mid-operation reset: pulse rst low asynchronously, between edges, while holding 5 words -> flags and pointers clear immediately; after release rd_empty=1 and the next written word is the next read.
